// File: rtl/skew_feeder.sv
// Feeds the systolic array west edge from ROWS show-ahead FIFOs with a diagonal skew:
// row r trails row 0 by r cycles, and any empty FIFO that is needed stalls every row together.
module skew_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 4,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic [LEN_WIDTH-1:0]       len_i,
    output logic                       busy_o,
    output logic                       done_o,
    input  logic [ROWS-1:0]            fifo_empty_i,
    output logic [ROWS-1:0]            fifo_rden_o,
    input  logic [ROWS*DATA_WIDTH-1:0] fifo_rdata_i,
    output logic [ROWS*DATA_WIDTH-1:0] data_o,
    output logic [ROWS-1:0]            valid_o
);
    localparam int CW = LEN_WIDTH + $clog2(ROWS) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [LEN_WIDTH-1:0] len_q;
    logic [CW-1:0]        len_x;
    logic [CW-1:0]        last_cnt;
    logic [ROWS-1:0]      need;
    logic                 stall;

    assign len_x    = CW'(len_q);
    assign last_cnt = len_x + CW'(ROWS) - CW'(2);

    // Row r is live for cnt in [r, r+len_q); the window slides one row per cycle.
    for (genvar r = 0; r < ROWS; r++) begin : g_need
        assign need[r] = (state == RUN) && (cnt >= CW'(r)) && (cnt < len_x + CW'(r));
    end

    assign stall       = |(need & fifo_empty_i);
    assign fifo_rden_o = need & ~{ROWS{stall}};
    assign busy_o      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            len_q   <= '0;
            done_o  <= 1'b0;
            valid_o <= '0;
            data_o  <= '0;
        end else begin
            done_o  <= 1'b0;
            valid_o <= fifo_rden_o;
            for (int r = 0; r < ROWS; r++) begin
                data_o[r*DATA_WIDTH +: DATA_WIDTH] <=
                    fifo_rden_o[r] ? fifo_rdata_i[r*DATA_WIDTH +: DATA_WIDTH] : '0;
            end
            case (state)
                IDLE: begin
                    if (start_i) begin
                        len_q <= len_i;
                        cnt   <= '0;
                        if (len_i != '0) begin
                            state <= RUN;
                        end else begin
                            state  <= FIN;
                            done_o <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!stall) begin
                        cnt <= cnt + CW'(1);
                        // Last read this cycle; its beat lands on data_o while in FIN.
                        if (cnt == last_cnt) begin
                            state  <= FIN;
                            done_o <= 1'b1;
                        end
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
